// File: rtl/button_event_queue_if.sv
// Bundle of the button pins, the CPU IO read port and the status outputs of the button event queue.
interface button_event_queue_if;
    logic [3:0]  btn;
    logic        rd_en;
    logic        clr_ovf;
    logic [31:0] rd_data;
    logic [3:0]  btn_level;
    logic [4:0]  count;

    modport master (
        output btn,
        output rd_en,
        output clr_ovf,
        input  rd_data,
        input  btn_level,
        input  count
    );

    modport slave (
        input  btn,
        input  rd_en,
        input  clr_ovf,
        output rd_data,
        output btn_level,
        output count
    );
endinterface

// File: rtl/button_event_queue.sv
// Synchronizes and debounces four push-buttons, then queues each press as an event
// that the CPU reads and pops through its memory-mapped IO read port.
module button_event_queue #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned CNT_W           = 18,
    parameter int unsigned DEPTH           = 8
) (
    input logic                 clock,
    input logic                 reset,
    button_event_queue_if.slave bus
);

    localparam int unsigned NB     = 4;
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned AW     = PTR_W + 1;
    localparam int unsigned OCC_W  = 5;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NB-1:0]    sync1_q, sync2_q;
    logic [NB-1:0]    stable_q, stable_d, stable_dly_q;
    logic [CNT_W-1:0] cnt_q [NB];
    logic [CNT_W-1:0] cnt_d [NB];

    logic [NB-1:0]    mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;

    logic [NB-1:0]    press;
    logic [NB-1:0]    head;
    logic             empty, full, pop, push_req, push, drop;

    // Per-bit debounce: a disagreement must persist for DEBOUNCE_CYCLES samples to flip stable
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < int'(NB); i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            stable_q     <= '0;
            stable_dly_q <= '0;
            for (int i = 0; i < int'(NB); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q      <= bus.btn;
            sync2_q      <= sync1_q;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            for (int i = 0; i < int'(NB); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign press    = stable_q & ~stable_dly_q;
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]) &&
                      (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]);
    assign pop      = bus.rd_en & ~empty;
    assign push_req = |press;
    // A pop in the same cycle frees a slot, so a full queue can still accept the push
    assign push     = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + OCC_W'(push) - OCC_W'(pop);
        ovf_d    = drop | (ovf_q & ~bus.clr_ovf);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage needs no reset: the head is masked whenever the pointers say empty
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= press;
        end
    end

    assign head          = empty ? '0 : mem_q[rd_ptr_q[PTR_W-1:0]];
    assign bus.rd_data   = {26'b0, ovf_q, ~empty, head};
    assign bus.btn_level = stable_q;
    assign bus.count     = count_q;

endmodule

// File: tb/tb_button_event_queue.sv
// Scoreboard bench for button_event_queue with a short debounce and a four-entry queue.
module tb_button_event_queue;

    logic clock;
    logic reset;

    button_event_queue_if bus();

    button_event_queue #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (18),
        .DEPTH          (4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic [3:0]  sb [$];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic pop_one();
        bus.rd_en = 1'b1;
        tick(1);
        bus.rd_en = 1'b0;
    endtask

    task automatic press_release(input logic [3:0] code, input bit expect_kept);
        bus.btn = code;
        if (expect_kept) sb.push_back(code);
        tick(8);
        bus.btn = 4'h0;
        tick(8);
    endtask

    // Monitor: every accepted pop must present the oldest expected code
    always @(negedge clock) begin
        if (reset && bus.rd_en && bus.rd_data[4]) begin
            if (sb.size() == 0) begin
                chk("unexpected_pop", {28'b0, bus.rd_data[3:0]}, 32'h0);
            end else begin
                chk("pop_head", {28'b0, bus.rd_data[3:0]}, {28'b0, sb.pop_front()});
            end
        end
    end

    initial begin
        reset       = 1'b0;
        bus.btn     = 4'hF;
        bus.rd_en   = 1'b0;
        bus.clr_ovf = 1'b0;

        // Reset held with all buttons down
        tick(20);
        chk("rst_rd_data", bus.rd_data, 32'h0);
        chk("rst_count", {27'b0, bus.count}, 32'h0);
        chk("rst_level", {28'b0, bus.btn_level}, 32'h0);
        reset = 1'b1;
        sb.push_back(4'hF);
        tick(6);
        chk("rst_rel_lat6", {27'b0, bus.count}, 32'h0);
        tick(1);
        chk("rst_rel_lat7", bus.rd_data, 32'h1F);
        chk("rst_rel_level", {28'b0, bus.btn_level}, 32'hF);
        bus.btn = 4'h0;
        tick(10);
        chk("rst_rel_count", {27'b0, bus.count}, 32'h1);
        pop_one();
        chk("rst_rel_after_pop", bus.rd_data, 32'h0);

        // Single press and pop
        bus.btn = 4'h1;
        sb.push_back(4'h1);
        tick(6);
        chk("single_lat6", bus.rd_data, 32'h0);
        tick(1);
        chk("single_lat7", bus.rd_data, 32'h11);
        chk("single_count", {27'b0, bus.count}, 32'h1);
        chk("single_level", {28'b0, bus.btn_level}, 32'h1);
        pop_one();
        chk("single_pop_data", bus.rd_data, 32'h0);
        chk("single_pop_count", {27'b0, bus.count}, 32'h0);
        bus.btn = 4'h0;
        tick(10);

        // Glitch rejection on BTND
        for (int r = 0; r < 2; r++) begin
            bus.btn = 4'h2;
            for (int k = 0; k < 3; k++) begin
                tick(1);
                chk("glitch_level_hi", {31'b0, bus.btn_level[1]}, 32'h0);
            end
            bus.btn = 4'h0;
            tick(1);
            chk("glitch_level_lo", {31'b0, bus.btn_level[1]}, 32'h0);
        end
        tick(10);
        chk("glitch_count", {27'b0, bus.count}, 32'h0);
        chk("glitch_level_end", {28'b0, bus.btn_level}, 32'h0);
        bus.btn = 4'h2;
        sb.push_back(4'h2);
        tick(10);
        chk("hold_rd_data", bus.rd_data, 32'h12);
        chk("hold_level", {28'b0, bus.btn_level}, 32'h2);
        bus.btn = 4'h0;
        tick(10);
        chk("hold_release_count", {27'b0, bus.count}, 32'h1);
        pop_one();

        // Simultaneous press
        bus.btn = 4'h5;
        sb.push_back(4'h5);
        tick(7);
        chk("simul_rd_data", bus.rd_data, 32'h15);
        chk("simul_count", {27'b0, bus.count}, 32'h1);
        bus.btn = 4'h0;
        tick(10);
        pop_one();

        // Overflow: fifth press is dropped
        press_release(4'h1, 1'b1);
        press_release(4'h2, 1'b1);
        press_release(4'h4, 1'b1);
        press_release(4'h8, 1'b1);
        press_release(4'h3, 1'b0);
        chk("ovf_count", {27'b0, bus.count}, 32'h4);
        chk("ovf_rd_data", bus.rd_data, 32'h31);
        for (int k = 0; k < 4; k++) pop_one();
        chk("ovf_drained", bus.rd_data, 32'h20);
        bus.clr_ovf = 1'b1;
        tick(1);
        bus.clr_ovf = 1'b0;
        chk("ovf_cleared", bus.rd_data, 32'h0);

        // Push and pop in the same cycle while full
        press_release(4'h1, 1'b1);
        press_release(4'h2, 1'b1);
        press_release(4'h4, 1'b1);
        press_release(4'h8, 1'b1);
        bus.btn = 4'h3;
        sb.push_back(4'h3);
        tick(6);
        bus.rd_en = 1'b1;
        tick(1);
        bus.rd_en = 1'b0;
        chk("full_pp_count", {27'b0, bus.count}, 32'h4);
        chk("full_pp_rd_data", bus.rd_data, 32'h12);
        bus.btn = 4'h0;
        tick(8);
        for (int k = 0; k < 4; k++) pop_one();
        chk("full_pp_drained", {27'b0, bus.count}, 32'h0);
        pop_one();
        chk("empty_pop_count", {27'b0, bus.count}, 32'h0);
        chk("empty_pop_data", bus.rd_data, 32'h0);

        // Reset mid-operation
        press_release(4'h1, 1'b0);
        press_release(4'h2, 1'b0);
        press_release(4'h4, 1'b0);
        chk("mid_count3", {27'b0, bus.count}, 32'h3);
        bus.btn = 4'h8;
        tick(3);
        reset = 1'b0;
        #2;
        chk("mid_rst_count", {27'b0, bus.count}, 32'h0);
        chk("mid_rst_rd_data", bus.rd_data, 32'h0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        sb.delete();
        sb.push_back(4'h8);
        tick(6);
        chk("mid_lat6", {27'b0, bus.count}, 32'h0);
        tick(1);
        chk("mid_lat7", bus.rd_data, 32'h18);
        bus.btn = 4'h0;
        tick(10);
        pop_one();
        chk("mid_final_count", {27'b0, bus.count}, 32'h0);
        chk("sb_empty", sb.size(), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
